// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// The optional read buffer is enabled with the DMEM_RDBUF_EN macro.
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
    localparam int          WORD_TAG_W   = 30;
endpackage

// File: rtl/dmem_rdbuf.sv
// One-entry read buffer: remembers the last completed read word.
// Instantiated by dmem_ctrl only when DMEM_RDBUF_EN is defined.
module dmem_rdbuf import dmem_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_TAG_W-1:0] lookup_tag,
    input  logic                  fill,
    input  logic                  upd,
    input  logic                  inval,
    input  logic [WORD_TAG_W-1:0] wr_tag,
    input  logic [31:0]           fill_data,
    input  logic [31:0]           upd_data,
    output logic                  hit,
    output logic [31:0]           data
);
    logic                  valid;
    logic [WORD_TAG_W-1:0] tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            data  <= fill_data;
        end else if (upd && valid && tag == wr_tag) begin
            // keep the buffered word coherent with stores to it
            data <= upd_data;
        end
    end

    assign hit = valid && (tag == lookup_tag);
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: req/ack handshake to wait-stated memory, stalls the core.
// Optional one-entry read buffer when DMEM_RDBUF_EN is defined.
module dmem_ctrl import dmem_pkg::*; #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    dmem_state_t      state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rdata_q;
    logic             req, rd, aligned, hit, tmo;

    assign req     = MemRead | MemWrite;
    assign rd      = MemRead & ~MemWrite;
    assign aligned = (ALUResult[1:0] == 2'b00);
    assign tmo     = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef DMEM_RDBUF_EN
    logic        buf_hit, fill, upd, inval;
    logic [31:0] buf_data;

    assign fill  = (state == BUSY) && mem_ack && !mem_we;
    assign upd   = (state == BUSY) && mem_ack && mem_we;
    assign inval = ((state == BUSY) && !mem_ack && tmo) ||
                   ((state == IDLE) && req && !aligned);

    dmem_rdbuf u_rdbuf (
        .clk        (clk),
        .rst        (reset),
        .lookup_tag (ALUResult[31:2]),
        .fill       (fill),
        .upd        (upd),
        .inval      (inval),
        .wr_tag     (mem_addr[31:2]),
        .fill_data  (mem_rdata),
        .upd_data   (mem_wdata),
        .hit        (buf_hit),
        .data       (buf_data)
    );

    assign hit      = (state == IDLE) && rd && aligned && buf_hit;
    assign ReadData = hit ? buf_data : rdata_q;
`else
    assign hit      = 1'b0;
    assign ReadData = rdata_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req && !hit) next_state = aligned ? BUSY : DONE;
            BUSY: if (mem_ack || tmo) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Stall = ((state == IDLE) && req && !hit) || (state == BUSY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            MemErr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        if (aligned) begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[31:2], 2'b00};
                            mem_wdata <= WriteData;
                            cnt       <= '0;
                        end else begin
                            // misaligned: never reaches memory, stores are dropped
                            MemErr <= 1'b1;
                            if (rd) rdata_q <= ERR_DATA;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata_q <= mem_rdata;
                    end else if (tmo) begin
                        mem_req <= 1'b0;
                        MemErr  <= 1'b1;
                        if (!mem_we) rdata_q <= ERR_DATA;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller for the ARM single-cycle processor, directly downstream of the datapath. It takes the datapath's `ALUResult` (address) and `WriteData`, plus the controller's `MemWrite`/`MemRead`, and drives a wait-stated external data memory through a req/ack handshake. It returns `ReadData` to the datapath's result mux. While an access is outstanding it holds `Stall` high so the core freezes PC and register writes.

## Interface
- `TIMEOUT`, default 16: maximum BUSY cycles without `mem_ack` before the access is aborted.
- `ERR_DATA`, default 32'hDEADBEEF: `ReadData` value returned on a timed-out or misaligned read.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  load request from the controller.
- `MemWrite`  in  1  store request from the controller; `MemWrite` has priority if both are high.
- `ALUResult`  in  32  byte address.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data to the result mux.
- `Stall`  out  1  core must hold state this cycle.
- `MemErr`  out  1  sticky error: timeout or misaligned address.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  write enable, registered.
- `mem_addr`  out  32  word-aligned address, registered.
- `mem_wdata`  out  32  store data, registered.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  one-cycle completion pulse from memory.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - On `MemRead|MemWrite`, with no buffer hit and an aligned address: capture address, data and `we` into the `mem_*` registers, then go to BUSY.
  - Misaligned address (`ALUResult[1:0]!=0`): do not touch memory. Set `MemErr`. Load `rdata_q=ERR_DATA` for reads; writes are dropped. Go to DONE.
- **BUSY**
  - `mem_req=1`; wait-counter increments each cycle.
  - On `mem_ack`: `rdata_q<=mem_rdata` if the access is a read. Go to DONE.
  - If the counter reaches `TIMEOUT-1` without ack: set `MemErr`, `rdata_q<=ERR_DATA` for a read, go to DONE. Drop `mem_req` at the next edge.
- **DONE**
  - `Stall=0`; the core completes the instruction using `ReadData=rdata_q`.
  - Go to IDLE unconditionally. A request still present in DONE is not restarted.
- `Stall` is combinational: `(IDLE & (MemRead|MemWrite) & ~hit) | BUSY`.
- `ReadData` is the buffer data on a hit in IDLE; otherwise `rdata_q`.
- `mem_ack` outside BUSY is ignored.
- `MemErr` is cleared only by `reset`.

## Timing
- **Reset values:** state=IDLE; `mem_req`=`mem_we`=0; `mem_addr`=`mem_wdata`=0; `rdata_q`=0; `MemErr`=0; wait-counter=0; read buffer invalid.
- **Request in cycle T:** `Stall` is high in T; BUSY with `mem_req=1` from T+1.
- **`mem_ack` in cycle T+k (k≥1):** DONE in T+k+1 with `Stall=0`; IDLE in T+k+2.
  - Best-case access costs 2 stall cycles.
- **Timeout:** DONE occurs TIMEOUT cycles after BUSY entry.
- **Back-to-back:** a new request is accepted only in IDLE, so there is a minimum of one idle cycle between accesses.
- **Reset mid-BUSY:** `mem_req` drops asynchronously and `Stall` releases immediately. The memory must tolerate an abandoned request.

## Configuration
- `DMEM_RDBUF_EN` defined: one-entry read buffer with valid bit, 30-bit word tag and 32-bit data.
  - A read in IDLE whose tag matches a valid entry is a hit: `Stall=0` and `ReadData`=buffer data, same cycle, with no memory access.
  - A completed read fills the buffer.
  - A completed write to the matching tag updates the buffer data.
  - Timeout or error invalidates the buffer.
- `DMEM_RDBUF_EN` undefined: no buffer and `hit` is tied to 0. Every access goes through the FSM.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum `dmem_state_t` (IDLE/BUSY/DONE);
  - the `ERR_DATA` default;
  - the `WORD_TAG_W=30` constant.
- One sub-module: `dmem_rdbuf`, the one-entry read buffer. It is instantiated only under `DMEM_RDBUF_EN`.
- The FSM, wait-counter and output registers stay in `dmem_ctrl`.

## Test plan
- **Read with ack one cycle after `mem_req`:** `MemRead`=1, `ALUResult`=0x40, memory returns 0x12345678.
  - `Stall` high for 2 cycles, then `ReadData`=0x12345678 in DONE.
  - `mem_addr`=0x40, `mem_we`=0.
- **Write:** `MemWrite`=1, addr 0x80, `WriteData`=0xCAFEF00D, ack after 3 cycles.
  - `mem_we`=1 and `mem_wdata`=0xCAFEF00D for the whole of BUSY.
  - `Stall` high for 4 cycles.
- **Timeout:** read to 0x100, `mem_ack` never asserted.
  - DONE after 16 BUSY cycles; `ReadData`=0xDEADBEEF; `MemErr`=1 and stays 1.
- **Misaligned read:** addr 0x42.
  - `mem_req` never rises; one stall cycle; `ReadData`=0xDEADBEEF; `MemErr`=1.
- **Reset asserted in the 2nd BUSY cycle:**
  - `mem_req`, `Stall` and `MemErr` go to 0 immediately; state is IDLE.
  - A late `mem_ack` is ignored.
- **With `DMEM_RDBUF_EN`:** read 0x40 (miss, 2 stalls), then read 0x40 again.
  - The second read gives `Stall`=0 and the same-cycle `ReadData`, with no `mem_req`.
  - Then write 0x40=0x1, then read 0x40: hit returns 0x1.
